// File: rtl/weight_tile_loader.sv
// Weight-FIFO writer: packs an input byte stream into weight rows.
// Loads num_tiles tiles of ROWS_PER_TILE rows, then pulses done.
module weight_tile_loader #(
  parameter int ROW_BYTES     = 3,
  parameter int ROWS_PER_TILE = 3,
  parameter int DATA_W        = 64,
  parameter int TILE_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wt_fifo_wr,
  output logic [DATA_W-1:0] wt_fifo_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rows_pushed
);

  localparam int RW  = 8 * ROW_BYTES;
  localparam int BW  = $clog2(ROW_BYTES + 1);
  localparam int RCW = $clog2(ROWS_PER_TILE + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUSH,
    FIN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TILE_W-1:0] tiles_q;
  logic [TILE_W-1:0] tile_cnt;
  logic [RCW-1:0]    row_cnt;
  logic [BW-1:0]     byte_cnt;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     row_d;
  logic              hs;
  logic              go;
  logic              last_byte;
  logic              last_row;
  logic              last_tile;

  assign hs        = in_valid && in_ready;
  assign go        = start && !abort;
  assign last_byte = byte_cnt == BW'(ROW_BYTES - 1);
  assign last_row  = row_cnt == RCW'(ROWS_PER_TILE - 1);
  assign last_tile = tile_cnt == tiles_q - 1'b1;

  always_comb begin
    row_d = row_q;
    for (int k = 0; k < ROW_BYTES; k++) begin
      if (hs && byte_cnt == BW'(k)) begin
        row_d[8*k +: 8] = in_data;
      end
    end
  end

  // abort outranks every other event, including a completing byte
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = (num_tiles != '0) ? COLLECT : FIN;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs && last_byte) begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_row && last_tile) begin
          state_d = FIN;
        end else begin
          state_d = COLLECT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready     <= 1'b0;
      wt_fifo_wr   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wt_fifo_data <= '0;
      rows_pushed  <= '0;
      tiles_q      <= '0;
      tile_cnt     <= '0;
      row_cnt      <= '0;
      byte_cnt     <= '0;
      row_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready   <= state_d == COLLECT;
      wt_fifo_wr <= state_d == PUSH;
      busy       <= (state_d == COLLECT) || (state_d == PUSH);
      done       <= state_d == FIN;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            tiles_q     <= num_tiles;
            tile_cnt    <= '0;
            row_cnt     <= '0;
            byte_cnt    <= '0;
            row_q       <= '0;
            rows_pushed <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            byte_cnt <= '0;
          end else if (hs) begin
            row_q <= row_d;
            if (last_byte) begin
              byte_cnt     <= '0;
              wt_fifo_data <= {{(DATA_W - RW){1'b0}}, row_d};
              rows_pushed  <= rows_pushed + 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        PUSH: begin
          byte_cnt <= '0;
          if (last_row) begin
            row_cnt  <= '0;
            tile_cnt <= tile_cnt + 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        FIN: begin
          byte_cnt <= '0;
        end
        default: begin
          byte_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Bench for weight_tile_loader: row scoreboard plus
// scenario tasks for reset, backpressure, abort and start corner cases.
module tb_weight_tile_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_tiles = 8'd0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        wt_fifo_wr;
  logic [63:0] wt_fifo_data;
  logic        busy;
  logic        done;
  logic [15:0] rows_pushed;

  weight_tile_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_tiles    (num_tiles),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wt_fifo_wr   (wt_fifo_wr),
    .wt_fifo_data (wt_fifo_data),
    .busy         (busy),
    .done         (done),
    .rows_pushed  (rows_pushed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int done_cyc = 0;
  int rd = 0;
  logic [63:0] obs_data [0:4095];
  int          obs_cyc  [0:4095];
  logic [63:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  // observe on the falling edge, away from the DUT update
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wt_fifo_wr && push_cnt < 4096) begin
      obs_data[push_cnt] = wt_fifo_data;
      obs_cyc[push_cnt]  = cyc;
      push_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic ab);
    start     = 1'b1;
    num_tiles = n;
    abort     = ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit rnd);
    int g = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input bit rnd);
    sb.push_back({40'h0, b2, b1, b0});
    send_byte(b0, rnd);
    send_byte(b1, rnd);
    send_byte(b2, rnd);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int g = 0;
    in_valid = 1'b0;
    while (done_cnt == d0 && g < 200) begin
      tick();
      g++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_done_timeout got no done expected a pulse", tag);
    end
  endtask

  task automatic scoreboard_drain(input string tag);
    logic [63:0] exp;
    while (rd < push_cnt) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_unexpected_push got %h expected none",
                 tag, obs_data[rd]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd] !== exp) begin
          errors++;
          $display("FAIL %s_push_data got %h expected %h",
                   tag, obs_data[rd], exp);
        end
      end
      rd++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_push got %0d rows pending expected 0",
               tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int p0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, wt_fifo_wr, busy, done} !== 4'b0 ||
        wt_fifo_data !== 64'h0 || rows_pushed !== 16'h0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b wr=%b busy=%b done=%b data=%h rows=%0d expected all 0",
               in_ready, wt_fifo_wr, busy, done, wt_fifo_data, rows_pushed);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    do_start(8'd1, 1'b0);
    send_row(8'hA1, 8'hA2, 8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    p0 = push_cnt;
    checks++;
    if (busy !== 1'b1 || rows_pushed !== 16'd1) begin
      errors++;
      $display("FAIL reset_preload got busy=%b rows=%0d expected busy=1 rows=1",
               busy, rows_pushed);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, wt_fifo_wr, busy, done} !== 4'b0 ||
        wt_fifo_data !== 64'h0 || rows_pushed !== 16'h0) begin
      errors++;
      $display("FAIL reset_async got rdy=%b wr=%b busy=%b done=%b data=%h rows=%0d expected all 0",
               in_ready, wt_fifo_wr, busy, done, wt_fifo_data, rows_pushed);
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || push_cnt != p0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b rdy=%b pushes=%0d expected 0 0 %0d",
               busy, in_ready, push_cnt, p0);
    end
    scoreboard_drain("reset");
  endtask

  task automatic test_single_tile();
    int p0 = push_cnt;
    int d0 = done_cnt;
    do_start(8'd1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      send_row(8'(3*r+1), 8'(3*r+2), 8'(3*r+3), 1'b0);
    end
    wait_done(d0, "single");
    repeat (3) tick();
    checks++;
    if (push_cnt - p0 != 3) begin
      errors++;
      $display("FAIL single_count got %0d expected 3", push_cnt - p0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (obs_cyc[p0+i] - obs_cyc[p0+i-1] != 4) begin
          errors++;
          $display("FAIL single_spacing got %0d expected 4",
                   obs_cyc[p0+i] - obs_cyc[p0+i-1]);
        end
      end
      checks++;
      if (done_cyc - obs_cyc[p0+2] != 1) begin
        errors++;
        $display("FAIL single_done_latency got %0d expected 1",
                 done_cyc - obs_cyc[p0+2]);
      end
    end
    checks++;
    if (rows_pushed !== 16'd3 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single_status got rows=%0d dones=%0d expected 3 1",
               rows_pushed, done_cnt - d0);
    end
    scoreboard_drain("single");
  endtask

  task automatic test_backpressure();
    int p0 = push_cnt;
    int d0 = done_cnt;
    do_start(8'd2, 1'b0);
    for (int r = 0; r < 6; r++) begin
      send_row(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end
    wait_done(d0, "bp");
    repeat (3) tick();
    checks++;
    if (push_cnt - p0 != 6 || done_cnt - d0 != 1 || rows_pushed !== 16'd6) begin
      errors++;
      $display("FAIL bp_status got pushes=%0d dones=%0d rows=%0d expected 6 1 6",
               push_cnt - p0, done_cnt - d0, rows_pushed);
    end
    scoreboard_drain("bp");
  endtask

  task automatic test_zero_tiles();
    int p0 = push_cnt;
    int d0 = done_cnt;
    int b0 = busy_cnt;
    do_start(8'd0, 1'b0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got %b expected 1", done);
    end
    repeat (4) tick();
    checks++;
    if (push_cnt != p0 || busy_cnt != b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_status got pushes=%0d busy_cycles=%0d dones=%0d expected 0 0 1",
               push_cnt - p0, busy_cnt - b0, done_cnt - d0);
    end
    scoreboard_drain("zero");
  endtask

  task automatic test_abort();
    int p0 = push_cnt;
    int d0 = done_cnt;
    do_start(8'd2, 1'b0);
    send_row(8'h10, 8'h11, 8'h12, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h14, 1'b0);
    // sixth byte completes a row in the same cycle as the abort
    in_valid = 1'b1;
    in_data  = 8'h15;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || rows_pushed !== 16'd1) begin
      errors++;
      $display("FAIL abort_idle got busy=%b rdy=%b rows=%0d expected 0 0 1",
               busy, in_ready, rows_pushed);
    end
    repeat (5) tick();
    checks++;
    if (push_cnt - p0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL abort_quiet got pushes=%0d dones=%0d expected 1 0",
               push_cnt - p0, done_cnt - d0);
    end
    scoreboard_drain("abort");
    do_start(8'd1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      send_row(8'(8'h20+3*r), 8'(8'h21+3*r), 8'(8'h22+3*r), 1'b0);
    end
    wait_done(d0, "abort_reload");
    checks++;
    if (rows_pushed !== 16'd3 || push_cnt - p0 != 4) begin
      errors++;
      $display("FAIL abort_reload got rows=%0d pushes=%0d expected 3 4",
               rows_pushed, push_cnt - p0);
    end
    scoreboard_drain("abort_reload");
  endtask

  task automatic test_ignored_start();
    int p0 = push_cnt;
    int d0 = done_cnt;
    int b0;
    do_start(8'd1, 1'b0);
    send_row(8'h31, 8'h32, 8'h33, 1'b0);
    sb.push_back({40'h0, 8'h36, 8'h35, 8'h34});
    send_byte(8'h34, 1'b0);
    start     = 1'b1;
    num_tiles = 8'd7;
    send_byte(8'h35, 1'b0);
    start = 1'b0;
    send_byte(8'h36, 1'b0);
    send_row(8'h37, 8'h38, 8'h39, 1'b0);
    wait_done(d0, "ign");
    repeat (10) tick();
    checks++;
    if (push_cnt - p0 != 3 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_status got pushes=%0d dones=%0d busy=%b expected 3 1 0",
               push_cnt - p0, done_cnt - d0, busy);
    end
    scoreboard_drain("ign");
    b0 = busy_cnt;
    d0 = done_cnt;
    do_start(8'd2, 1'b1);
    repeat (5) tick();
    checks++;
    if (busy_cnt != b0 || in_ready !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL start_abort got busy_cycles=%0d rdy=%b dones=%0d expected 0 0 0",
               busy_cnt - b0, in_ready, done_cnt - d0);
    end
  endtask

  task automatic test_max_tiles();
    int p0 = push_cnt;
    int d0 = done_cnt;
    do_start(8'd255, 1'b0);
    for (int r = 0; r < 765; r++) begin
      send_row(8'(3*r), 8'(3*r+1), 8'(3*r+2), 1'b0);
    end
    wait_done(d0, "max");
    repeat (3) tick();
    checks++;
    if (push_cnt - p0 != 765 || rows_pushed !== 16'd765 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL max_status got pushes=%0d rows=%0d dones=%0d expected 765 765 1",
               push_cnt - p0, rows_pushed, done_cnt - d0);
    end
    scoreboard_drain("max");
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_zero_tiles();
    test_abort();
    test_ignored_start();
    test_max_tiles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
